adder_operand_loader: RTL and testbench
=======================================

Name: adder_operand_loader

Overview:
- Upstream stage for adder_datapath. Collects three WIDTH-bit operands from a valid/ready input stream, one word per handshake, and presents them on a, b and c.
- Holds the operands stable for the datapath's pipeline latency, then captures the datapath result y.
- Offers the captured result on a valid/ready output port.
- Processes one transaction at a time; there is no overlap between transactions.

Parameters:
- WIDTH, 16: operand and result width. Must match adder_datapath.
- ADD_LATENCY, 2: number of register stages in adder_datapath between a/b/c and y. 0 means a combinational adder.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  operand word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data on this cycle.
- a  out  WIDTH  operand A to the datapath (registered).
- b  out  WIDTH  operand B to the datapath (registered).
- c  out  WIDTH  operand C to the datapath (registered).
- y  in  WIDTH  datapath result.
- sum  out  WIDTH  captured result (registered).
- sum_valid  out  1  sum is valid.
- sum_ready  in  1  consumer accepts sum.

Behaviour:
- One clock; reset is synchronous and active-high, named reset, sampled only on rising clk.
- Reset values: state=LOAD_A, a=b=c=0, sum=0, sum_valid=0, wait counter=0. in_ready=1 in the first cycle after reset.
- FSM states: LOAD_A, LOAD_B, LOAD_C, WAIT, HOLD.
- in_ready is high only in LOAD_A, LOAD_B and LOAD_C, and is decoded combinationally from state.
- LOAD_A: on in_valid&&in_ready, a<=in_data and go to LOAD_B.
- LOAD_B: on handshake, b<=in_data and go to LOAD_C.
- LOAD_C: on handshake, c<=in_data, go to WAIT, and load cnt<=ADD_LATENCY.
- In any LOAD state with in_valid=0, the state and registers hold.
- WAIT:
  - If cnt==0: sum<=y, sum_valid<=1, go to HOLD.
  - Otherwise cnt<=cnt-1.
  - Net effect: if c is registered at edge t, y is sampled at edge t+ADD_LATENCY+1.
- HOLD:
  - sum_valid=1 and sum is stable.
  - On sum_ready=1: sum_valid<=0, go to LOAD_A.
  - With sum_ready=0, hold indefinitely.
- a, b and c are never cleared between transactions. Each register keeps its value until it is overwritten by its own LOAD state.
- Minimum transaction time with no stalls: 3 load cycles + (ADD_LATENCY+1) wait cycles + 1 hold cycle.
- Arithmetic: none in the loader. sum is y verbatim, i.e. the datapath's modulo 2^WIDTH result; the carry is not visible.
- sum_ready asserted outside HOLD is ignored.
- in_valid asserted in WAIT or HOLD is not accepted: in_ready=0 and the word is not consumed.
- Reset mid-operation, in any state: a partial operand set is discarded, all registers return to their reset values, and a pending sum is dropped with sum_valid=0 on the next cycle.
- cnt width is clog2(ADD_LATENCY+1), with a minimum of 1 bit.

Decomposition:
- Shared header/package adder_defs holds:
  - the WIDTH default;
  - the state encodings (LOAD_A=0, LOAD_B=1, LOAD_C=2, WAIT=3, HOLD=4, 3-bit);
  - the ADD_LATENCY default, kept consistent with adder_datapath.
- No sub-module is required; the FSM plus the wait counter fit in one module.
- adder_datapath is instantiated beside the loader at the enclosing level, not inside it.

Test Plan:
- Basic: send in_data 0x0654, 0x0456, 0x0555 back-to-back with sum_ready=1.
  - Expect a=0x0654, b=0x0456, c=0x0555.
  - Expect sum=0x0FFF with sum_valid high exactly ADD_LATENCY+1 cycles after c is registered, for one cycle.
- Overflow: send 0xFFFF, 0x0001, 0x0002 -> sum=0x0002 and sum_valid=1.
- Stalls:
  - Drop in_valid for 3 cycles between b and c -> state held in LOAD_C, a and b unchanged, final sum correct.
  - Hold sum_ready=0 for 5 cycles in HOLD -> sum and sum_valid stable, in_ready=0, and an in_valid word offered during HOLD is not consumed.
- Reset mid-operation: assert reset in WAIT after 0x0010 and 0x0020 have loaded -> next cycle a=b=c=0, sum_valid=0, in_ready=1. A subsequent 1, 2, 3 gives sum=0x0006.
- Back-to-back transactions: run 10 random triples with random valid/ready gaps against a reference model ((a+b+c) mod 2^16) -> zero mismatches. Sweep ADD_LATENCY over 0, 1 and 2.

Source files
------------

// File: rtl/adder_defs.sv
// Shared defaults and FSM encoding for the adder operand loader and the
// adder datapath that sits beside it at the enclosing level.
package adder_defs;

    // Operand/result width shared by the loader and the datapath.
    localparam int DEFAULT_WIDTH = 16;

    // Register stages inside adder_datapath between a/b/c and y.
    localparam int DEFAULT_ADD_LATENCY = 2;

    // Loader FSM encoding; the numeric values are fixed so that other
    // blocks and debug tooling can decode the state bus directly.
    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } loader_state_t;

    // Width of the wait counter: enough to hold ADD_LATENCY, never zero bits.
    function automatic int cntWidth(input int latency);
        return (latency > 0) ? $clog2(latency + 1) : 1;
    endfunction

endpackage

// File: rtl/adder_operand_loader.sv
// Collects three operand words from a valid/ready stream, presents them to
// adder_datapath, waits out its pipeline latency, captures y and offers the
// result on a valid/ready output. One transaction is in flight at a time.
module adder_operand_loader
    import adder_defs::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ADD_LATENCY = DEFAULT_ADD_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready
);

    localparam int               CNT_W    = cntWidth(ADD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LATENCY);

    loader_state_t    state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] sum_q;
    logic             sumValid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             inAccept;

    // Input readiness is a pure decode of the state so it is valid as soon
    // as the state register settles; only the three load states take words.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LOAD_A, LOAD_B, LOAD_C: in_ready = 1'b1;
            default:                in_ready = 1'b0;
        endcase
    end

    assign inAccept = in_valid && in_ready;

    // Single FSM: operand capture, latency countdown, result capture and
    // output handshake. Operands are never cleared between transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_A;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            sum_q      <= '0;
            sumValid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (inAccept) begin
                        a_q     <= in_data;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (inAccept) begin
                        b_q     <= in_data;
                        state_q <= LOAD_C;
                    end
                end
                LOAD_C: begin
                    if (inAccept) begin
                        c_q     <= in_data;
                        cnt_q   <= CNT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        sum_q      <= y;
                        sumValid_q <= 1'b1;
                        state_q    <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        sumValid_q <= 1'b0;
                        state_q    <= LOAD_A;
                    end
                end
                default: begin
                    sumValid_q <= 1'b0;
                    state_q    <= LOAD_A;
                end
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign sum       = sum_q;
    assign sum_valid = sumValid_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Bench for adder_operand_loader. Three loaders run beside behavioural
// datapaths of latency 0, 1 and 2; expected sums come from plain modulo
// arithmetic on the words that were sent.
module tb_adder_operand_loader;

    logic        clk;
    logic        rst      [3];
    logic [15:0] inData   [3];
    logic        inValid  [3];
    logic        inReady  [3];
    logic [15:0] aOut     [3];
    logic [15:0] bOut     [3];
    logic [15:0] cOut     [3];
    logic [15:0] sumOut   [3];
    logic        sumValid [3];
    logic        sumReady [3];
    logic [15:0] yL0;
    logic [15:0] yL1;
    logic [15:0] yL2;
    logic [15:0] pipe2;

    int checks;
    int errors;

    adder_operand_loader #(.WIDTH(16), .ADD_LATENCY(0)) dut0 (
        .clk(clk), .reset(rst[0]), .in_data(inData[0]), .in_valid(inValid[0]),
        .in_ready(inReady[0]), .a(aOut[0]), .b(bOut[0]), .c(cOut[0]), .y(yL0),
        .sum(sumOut[0]), .sum_valid(sumValid[0]), .sum_ready(sumReady[0]));

    adder_operand_loader #(.WIDTH(16), .ADD_LATENCY(1)) dut1 (
        .clk(clk), .reset(rst[1]), .in_data(inData[1]), .in_valid(inValid[1]),
        .in_ready(inReady[1]), .a(aOut[1]), .b(bOut[1]), .c(cOut[1]), .y(yL1),
        .sum(sumOut[1]), .sum_valid(sumValid[1]), .sum_ready(sumReady[1]));

    adder_operand_loader #(.WIDTH(16), .ADD_LATENCY(2)) dut2 (
        .clk(clk), .reset(rst[2]), .in_data(inData[2]), .in_valid(inValid[2]),
        .in_ready(inReady[2]), .a(aOut[2]), .b(bOut[2]), .c(cOut[2]), .y(yL2),
        .sum(sumOut[2]), .sum_valid(sumValid[2]), .sum_ready(sumReady[2]));

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in datapaths with 0, 1 and 2 register stages.
    assign yL0 = aOut[0] + bOut[0] + cOut[0];

    always_ff @(posedge clk) begin
        yL1 <= aOut[1] + bOut[1] + cOut[1];
    end

    always_ff @(posedge clk) begin
        pipe2 <= aOut[2] + bOut[2] + cOut[2];
        yL2   <= pipe2;
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] refSum(input logic [15:0] x0, input logic [15:0] x1,
                                           input logic [15:0] x2);
        int total;
        total = int'(x0) + int'(x1) + int'(x2);
        return 16'(total % 65536);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic applyStimulus(input int k, input logic [15:0] w, input string tag);
        bit done;
        bit rdy;
        done       = 1'b0;
        inData[k]  = w;
        inValid[k] = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            rdy = inReady[k];
            tick();
            done = rdy;
        end
        inValid[k] = 1'b0;
        checkOutput({tag, "_accept"}, 32'(done), 1);
    endtask

    task automatic waitValid(input int k, input string tag);
        for (int n = 0; n < 100 && !sumValid[k]; n++) tick();
        checkOutput({tag, "_valid"}, 32'(sumValid[k]), 1);
    endtask

    // Wait for the result, check it, optionally stall the consumer, drain it.
    task automatic collectSum(input int k, input logic [15:0] exp, input string tag,
                              input bit randomStall);
        for (int n = 0; n < 100 && !sumValid[k]; n++) begin
            if (randomStall) sumReady[k] = 1'($urandom_range(0, 1));
            tick();
        end
        checkOutput({tag, "_valid"}, 32'(sumValid[k]), 1);
        checkOutput({tag, "_sum"}, 32'(sumOut[k]), 32'(exp));
        if (!sumReady[k]) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                checkOutput({tag, "_stallValid"}, 32'(sumValid[k]), 1);
                checkOutput({tag, "_stallSum"}, 32'(sumOut[k]), 32'(exp));
            end
            sumReady[k] = 1'b1;
        end
        tick();
        checkOutput({tag, "_drained"}, 32'(sumValid[k]), 0);
        checkOutput({tag, "_readyAgain"}, 32'(inReady[k]), 1);
    endtask

    task automatic runTriple(input int k, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input string tag);
        applyStimulus(k, w0, {tag, "A"});
        applyStimulus(k, w1, {tag, "B"});
        applyStimulus(k, w2, {tag, "C"});
        collectSum(k, refSum(w0, w1, w2), tag, 1'b0);
    endtask

    // Reset values, exact latency of the result, and overflow wrap.
    task automatic runBasic(input int k);
        rst[k] = 1'b1;
        tick();
        checkOutput("rst_inReady", 32'(inReady[k]), 1);
        checkOutput("rst_sumValid", 32'(sumValid[k]), 0);
        checkOutput("rst_a", 32'(aOut[k]), 0);
        checkOutput("rst_b", 32'(bOut[k]), 0);
        checkOutput("rst_c", 32'(cOut[k]), 0);
        checkOutput("rst_sum", 32'(sumOut[k]), 0);
        rst[k] = 1'b0;

        sumReady[k] = 1'b1;
        applyStimulus(k, 16'h0654, "basicA");
        applyStimulus(k, 16'h0456, "basicB");
        applyStimulus(k, 16'h0555, "basicC");
        checkOutput("basic_a", 32'(aOut[k]), 32'h0654);
        checkOutput("basic_b", 32'(bOut[k]), 32'h0456);
        checkOutput("basic_c", 32'(cOut[k]), 32'h0555);
        checkOutput("basic_waitValid", 32'(sumValid[k]), 0);
        checkOutput("basic_waitReady", 32'(inReady[k]), 0);
        for (int i = 1; i <= k + 1; i++) begin
            tick();
            checkOutput($sformatf("basic_lat%0d_cyc%0d", k, i), 32'(sumValid[k]),
                        32'(i == k + 1));
        end
        checkOutput("basic_sum", 32'(sumOut[k]), 32'h0FFF);
        tick();
        checkOutput("basic_oneCycle", 32'(sumValid[k]), 0);
        checkOutput("basic_backToLoad", 32'(inReady[k]), 1);

        runTriple(k, 16'hFFFF, 16'h0001, 16'h0002, "ovf");
    endtask

    // Input gap in LOAD_C, consumer stall in HOLD with a word offered.
    task automatic runStalls();
        sumReady[2] = 1'b1;
        applyStimulus(2, 16'h1111, "gapA");
        applyStimulus(2, 16'h2222, "gapB");
        repeat (3) begin
            tick();
            checkOutput("gap_inReady", 32'(inReady[2]), 1);
            checkOutput("gap_a", 32'(aOut[2]), 32'h1111);
            checkOutput("gap_b", 32'(bOut[2]), 32'h2222);
        end
        applyStimulus(2, 16'h3333, "gapC");
        collectSum(2, refSum(16'h1111, 16'h2222, 16'h3333), "gap", 1'b0);

        sumReady[2] = 1'b0;
        applyStimulus(2, 16'h0100, "holdA");
        applyStimulus(2, 16'h0200, "holdB");
        applyStimulus(2, 16'h0300, "holdC");
        waitValid(2, "hold");
        inData[2]  = 16'hBEEF;
        inValid[2] = 1'b1;
        repeat (5) begin
            tick();
            checkOutput("hold_valid", 32'(sumValid[2]), 1);
            checkOutput("hold_sum", 32'(sumOut[2]), 32'h0600);
            checkOutput("hold_inReady", 32'(inReady[2]), 0);
            checkOutput("hold_aKept", 32'(aOut[2]), 32'h0100);
        end
        inValid[2]  = 1'b0;
        sumReady[2] = 1'b1;
        tick();
        checkOutput("hold_release", 32'(sumValid[2]), 0);
        checkOutput("hold_notConsumed", 32'(aOut[2]), 32'h0100);
    endtask

    // Reset while waiting on the datapath and while holding a result.
    task automatic runResetTests();
        sumReady[2] = 1'b1;
        applyStimulus(2, 16'h0010, "midA");
        applyStimulus(2, 16'h0020, "midB");
        applyStimulus(2, 16'h0030, "midC");
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        checkOutput("mid_a", 32'(aOut[2]), 0);
        checkOutput("mid_b", 32'(bOut[2]), 0);
        checkOutput("mid_c", 32'(cOut[2]), 0);
        checkOutput("mid_sumValid", 32'(sumValid[2]), 0);
        checkOutput("mid_inReady", 32'(inReady[2]), 1);
        runTriple(2, 16'd1, 16'd2, 16'd3, "afterRst");

        sumReady[2] = 1'b0;
        applyStimulus(2, 16'h0004, "dropA");
        applyStimulus(2, 16'h0005, "dropB");
        applyStimulus(2, 16'h0006, "dropC");
        waitValid(2, "drop");
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        checkOutput("drop_sumValid", 32'(sumValid[2]), 0);
        checkOutput("drop_inReady", 32'(inReady[2]), 1);
        sumReady[2] = 1'b1;
    endtask

    // Random triples with random input gaps and consumer back-pressure.
    task automatic runRandom(input int k);
        logic [15:0] w [3];
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 3; i++) begin
                w[i] = 16'($urandom);
                sumReady[k] = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 2)) tick();
                applyStimulus(k, w[i], $sformatf("rnd%0d_%0d_w%0d", k, j, i));
            end
            collectSum(k, refSum(w[0], w[1], w[2]), $sformatf("rnd%0d_%0d", k, j), 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 3; k++) begin
            rst[k]      = 1'b1;
            inValid[k]  = 1'b0;
            inData[k]   = '0;
            sumReady[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        for (int k = 0; k < 3; k++) runBasic(k);
        runStalls();
        runResetTests();
        for (int k = 0; k < 3; k++) runRandom(k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
